// File: rtl/fnd_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver: each i_scan_clk toggle blanks the display for one cycle, then drives the next digit.
// Optional FND_LEADING_ZERO_BLANK_EN suppresses segments of leading zero digits 3..1.
module fnd_scan_driver #(
   parameter int COM_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_scan_clk,
   input  logic [15:0] i_bcd,
   input  logic [3:0]  i_dp,
   output logic [3:0]  o_com,
   output logic [7:0]  o_seg,
   output logic        o_frame,
   output logic [1:0]  o_dbg_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_DRIVE = 2'd2;

   localparam bit         COM_LOW = (COM_ACTIVE_LOW != 0);
   localparam bit         SEG_LOW = (SEG_ACTIVE_LOW != 0);
   localparam logic [3:0] COM_OFF = COM_LOW ? 4'hF : 4'h0;
   localparam logic [7:0] SEG_OFF = SEG_LOW ? 8'hFF : 8'h00;

   logic        r_sync1, r_sync2, r_hist;
   logic [1:0]  r_state, w_state_next;
   logic [1:0]  r_idx, w_idx_next;
   logic [15:0] r_snap_bcd;
   logic [3:0]  r_snap_dp;
   logic        w_step, w_snap, w_blank, w_dp;
   logic [3:0]  w_digit, w_com_on;
   logic [6:0]  w_pat;
   logic [7:0]  w_seg_on;

   assign w_step      = r_sync2 ^ r_hist;
   assign o_dbg_state = r_state;

   // A step seen while in BLANK is dropped; BLANK always lasts one cycle.
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      case (r_state)
         S_IDLE:  if (w_step) w_state_next = S_BLANK;
         S_BLANK: w_state_next = S_DRIVE;
         S_DRIVE: begin
            if (w_step) begin
               w_state_next = S_BLANK;
               w_idx_next   = r_idx + 2'd1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_snap = (w_state_next == S_BLANK) && (r_state != S_BLANK) && (w_idx_next == 2'd0);

   assign w_digit  = r_snap_bcd[{w_idx_next, 2'b00} +: 4];
   assign w_dp     = r_snap_dp[w_idx_next];
   assign w_com_on = 4'b0001 << w_idx_next;

   always_comb begin
      case (w_digit)
         4'd0:    w_pat = 7'h3F;
         4'd1:    w_pat = 7'h06;
         4'd2:    w_pat = 7'h5B;
         4'd3:    w_pat = 7'h4F;
         4'd4:    w_pat = 7'h66;
         4'd5:    w_pat = 7'h6D;
         4'd6:    w_pat = 7'h7D;
         4'd7:    w_pat = 7'h07;
         4'd8:    w_pat = 7'h7F;
         4'd9:    w_pat = 7'h6F;
         default: w_pat = 7'h40;
      endcase
   end

`ifdef FND_LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every digit above it are zero.
   always_comb begin
      case (w_idx_next)
         2'd3:    w_blank = (r_snap_bcd[15:12] == 4'd0);
         2'd2:    w_blank = (r_snap_bcd[15:8] == 8'd0);
         2'd1:    w_blank = (r_snap_bcd[15:4] == 12'd0);
         default: w_blank = 1'b0;
      endcase
   end
`else
   assign w_blank = 1'b0;
`endif

   assign w_seg_on = {w_dp, w_blank ? 7'd0 : w_pat};

   // Outputs are computed from the next state so they change on the same edge as the FSM.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_hist     <= 1'b0;
         r_state    <= S_IDLE;
         r_idx      <= 2'd0;
         r_snap_bcd <= 16'd0;
         r_snap_dp  <= 4'd0;
         o_frame    <= 1'b0;
         o_com      <= COM_OFF;
         o_seg      <= SEG_OFF;
      end else begin
         r_sync1 <= i_scan_clk;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         o_frame <= w_snap;
         if (w_snap) begin
            r_snap_bcd <= i_bcd;
            r_snap_dp  <= i_dp;
         end
         if (w_state_next == S_DRIVE) begin
            o_com <= COM_LOW ? ~w_com_on : w_com_on;
            o_seg <= SEG_LOW ? ~w_seg_on : w_seg_on;
         end else begin
            o_com <= COM_OFF;
            o_seg <= SEG_OFF;
         end
      end
   end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver: default-polarity instance plus an active-high instance sharing all inputs.
module tb_fnd_scan_driver;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_scan_clk = 1'b0;
   logic [15:0] i_bcd = 16'h1234;
   logic [3:0]  i_dp = 4'h0;
   logic [3:0]  o_com, h_com;
   logic [7:0]  o_seg, h_seg;
   logic        o_frame, h_frame;
   logic [1:0]  o_dbg_state, h_dbg_state;

   int   checks = 0;
   int   errors = 0;
   logic [3:0] prev_com = 4'hF;

   fnd_scan_driver dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_scan_clk(i_scan_clk),
      .i_bcd(i_bcd), .i_dp(i_dp),
      .o_com(o_com), .o_seg(o_seg), .o_frame(o_frame), .o_dbg_state(o_dbg_state)
   );

   fnd_scan_driver #(.COM_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) dut_hi (
      .i_clk(i_clk), .i_reset(i_reset), .i_scan_clk(i_scan_clk),
      .i_bcd(i_bcd), .i_dp(i_dp),
      .o_com(h_com), .o_seg(h_seg), .o_frame(h_frame), .o_dbg_state(h_dbg_state)
   );

   always #5 i_clk = ~i_clk;

   // One scan step with cycle-exact checks: toggle sampled at edge k, blank after k+2, digit after k+3.
   task automatic scan_step(input int digit, input logic [7:0] exp_seg, input logic exp_frame, input string tag);
      logic [3:0] exp_com;
      @(negedge i_clk);
      i_scan_clk = ~i_scan_clk;
      @(posedge i_clk);
      @(posedge i_clk);
      @(negedge i_clk);
      checks++;
      if (o_com !== prev_com) begin
         errors++;
         $display("FAIL %s_hold_k1 o_com=%b expected %b", tag, o_com, prev_com);
      end
      @(negedge i_clk);
      checks++;
      if (o_com !== 4'hF || o_seg !== 8'hFF || o_frame !== exp_frame) begin
         errors++;
         $display("FAIL %s_blank com=%b seg=%h frame=%b expected 1111/ff/%b", tag, o_com, o_seg, o_frame, exp_frame);
      end
      @(negedge i_clk);
      exp_com = 4'hF;
      exp_com[digit] = 1'b0;
      checks++;
      if (o_com !== exp_com || o_seg !== exp_seg || o_frame !== 1'b0) begin
         errors++;
         $display("FAIL %s_drive com=%b seg=%h frame=%b expected %b/%h/0", tag, o_com, o_seg, o_frame, exp_com, exp_seg);
      end
      prev_com = exp_com;
      repeat (14) @(negedge i_clk);
      checks++;
      if (o_com !== exp_com || o_seg !== exp_seg) begin
         errors++;
         $display("FAIL %s_held com=%b seg=%h expected %b/%h", tag, o_com, o_seg, exp_com, exp_seg);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge i_clk);
      checks++;
      if (o_com !== 4'hF || o_seg !== 8'hFF || o_frame !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs com=%b seg=%h frame=%b expected 1111/ff/0", o_com, o_seg, o_frame);
      end
      i_reset = 1'b0;
      repeat (10) @(negedge i_clk);
      checks++;
      if (o_com !== 4'hF || o_seg !== 8'hFF || o_frame !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle com=%b seg=%h frame=%b expected 1111/ff/0", o_com, o_seg, o_frame);
      end
   endtask

   task automatic test_scan();
      for (int r = 0; r < 2; r++) begin
         scan_step(0, 8'h99, 1'b1, "scan_d0");
         scan_step(1, 8'hB0, 1'b0, "scan_d1");
         scan_step(2, 8'hA4, 1'b0, "scan_d2");
         scan_step(3, 8'hF9, 1'b0, "scan_d3");
      end
   endtask

   task automatic test_mid_frame_change();
      scan_step(0, 8'h99, 1'b1, "mid_d0");
      scan_step(1, 8'hB0, 1'b0, "mid_d1");
      i_bcd = 16'h5678;
      scan_step(2, 8'hA4, 1'b0, "mid_old_d2");
      scan_step(3, 8'hF9, 1'b0, "mid_old_d3");
      scan_step(0, 8'h80, 1'b1, "mid_new_d0");
      scan_step(1, 8'hF8, 1'b0, "mid_new_d1");
      scan_step(2, 8'h82, 1'b0, "mid_new_d2");
      scan_step(3, 8'h92, 1'b0, "mid_new_d3");
   endtask

   task automatic test_step_in_blank();
      @(negedge i_clk);
      i_scan_clk = ~i_scan_clk;
      @(negedge i_clk);
      i_scan_clk = ~i_scan_clk;
      @(negedge i_clk);
      @(negedge i_clk);
      checks++;
      if (o_com !== 4'hF || o_frame !== 1'b1) begin
         errors++;
         $display("FAIL blank_step_blank com=%b frame=%b expected 1111/1", o_com, o_frame);
      end
      @(negedge i_clk);
      checks++;
      if (o_com !== 4'b1110 || o_seg !== 8'h80) begin
         errors++;
         $display("FAIL blank_step_drive com=%b seg=%h expected 1110/80", o_com, o_seg);
      end
      repeat (10) @(negedge i_clk);
      checks++;
      if (o_com !== 4'b1110 || o_seg !== 8'h80) begin
         errors++;
         $display("FAIL blank_step_ignored com=%b seg=%h expected 1110/80", o_com, o_seg);
      end
      prev_com = 4'b1110;
      scan_step(1, 8'hF8, 1'b0, "blank_step_next");
   endtask

   task automatic test_dash_dp();
      i_bcd = 16'h00A0;
      i_dp  = 4'b0100;
      scan_step(2, 8'h82, 1'b0, "dash_old_d2");
      scan_step(3, 8'h92, 1'b0, "dash_old_d3");
      scan_step(0, 8'hC0, 1'b1, "dash_d0");
      scan_step(1, 8'hBF, 1'b0, "dash_d1");
`ifdef FND_LEADING_ZERO_BLANK_EN
      scan_step(2, 8'h7F, 1'b0, "lzb_d2_dp_only");
      scan_step(3, 8'hFF, 1'b0, "lzb_d3_blank");
`else
      scan_step(2, 8'h40, 1'b0, "dash_d2_dp");
      scan_step(3, 8'hC0, 1'b0, "dash_d3");
`endif
   endtask

   task automatic test_polarity();
      i_bcd = 16'h0008;
      i_dp  = 4'h0;
      scan_step(0, 8'h80, 1'b1, "pol_d0");
      checks++;
      if (h_com !== 4'b0001 || h_seg !== 8'h7F) begin
         errors++;
         $display("FAIL pol_active_high com=%b seg=%h expected 0001/7f", h_com, h_seg);
      end
   endtask

   task automatic test_async_reset();
      @(negedge i_clk);
      #2 i_reset = 1'b1;
      #1;
      checks++;
      if (o_com !== 4'hF || o_seg !== 8'hFF || h_com !== 4'h0 || h_seg !== 8'h00) begin
         errors++;
         $display("FAIL async_reset com=%b seg=%h hcom=%b hseg=%h expected 1111/ff/0000/00", o_com, o_seg, h_com, h_seg);
      end
      i_scan_clk = 1'b0;
      @(negedge i_clk);
      i_reset = 1'b0;
      prev_com = 4'hF;
      repeat (10) @(negedge i_clk);
      checks++;
      if (o_com !== 4'hF || o_seg !== 8'hFF) begin
         errors++;
         $display("FAIL after_reset_idle com=%b seg=%h expected 1111/ff", o_com, o_seg);
      end
      scan_step(0, 8'h80, 1'b1, "after_reset_d0");
   endtask

   task automatic test_release_level();
      @(negedge i_clk);
      i_reset = 1'b1;
      i_scan_clk = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      repeat (8) @(negedge i_clk);
      checks++;
      if (o_com !== 4'b1110 || o_seg !== 8'h80) begin
         errors++;
         $display("FAIL release_level_step com=%b seg=%h expected 1110/80", o_com, o_seg);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_mid_frame_change();
      test_step_in_blank();
      test_dash_dp();
      test_polarity();
      test_async_reset();
      test_release_level();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fnd_scan_driver.md
FND_SCAN_DRIVER -- requirements
Module: fnd_scan_driver

Interface
REQ-001 Parameter: COM_ACTIVE_LOW, default 1, digit common outputs are active-low when 1 and active-high when 0.
REQ-002 Parameter: SEG_ACTIVE_LOW, default 1, segment outputs are active-low when 1 and active-high when 0.
REQ-003 i_clk  input  1  system clock; all state is clocked on its rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-high.
REQ-005 i_scan_clk  input  1  divided scan clock from the digit clock divider; every toggle (either edge) is one scan step; asynchronous to i_clk.
REQ-006 i_bcd  input  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 i_dp  input  4  decimal-point request per digit; bit n maps to digit n.
REQ-008 o_com  output  4  digit common select; bit n is digit n; at most one bit active at a time.
REQ-009 o_seg  output  8  segments; [0]=a … [6]=g, [7]=dp.
REQ-010 o_frame  output  1  one-cycle pulse, active-high, asserted when a new frame snapshot is taken.

Function
REQ-011 i_scan_clk shall pass through a 2-flop synchronizer followed by a history flop; step = sync2 XOR history.
REQ-012 FSM states: IDLE (outputs inactive, waits for the first step), BLANK (all commons and segments inactive for exactly one i_clk cycle), DRIVE (one digit active).
REQ-013 Transitions: IDLE --step--> BLANK; BLANK --> DRIVE unconditionally on the next cycle; DRIVE --step--> BLANK; otherwise the FSM holds its state.
REQ-014 Digit index shall be 0 on the first BLANK after reset; each subsequent DRIVE-to-BLANK transition shall advance it as 0,1,2,3,0,… with wrap from 3 to 0.
REQ-015 On entry to BLANK with index 0, i_bcd and i_dp shall be latched into a frame snapshot and o_frame pulsed; displayed data shall come only from the snapshot.
REQ-016 Latency: an i_scan_clk toggle sampled at edge k shall make outputs go inactive after edge k+2 and the next digit active after edge k+3.
REQ-017 A step arriving while in BLANK shall be ignored (no index advance, no extra BLANK).
REQ-018 Segment decode for BCD values 0-9 shall be standard 7-segment (e.g. 0=a..f, 1=b,c, 8=a..g); values 10-15 shall light only g (dash).
REQ-019 dp (o_seg[7]) shall be active in DRIVE when the snapshot dp bit of the current digit is 1.
REQ-020 o_com, o_seg and o_frame shall be registered outputs, free of glitches, and o_com shall never have two digits active.
REQ-021 Changes on i_bcd/i_dp during a frame shall not affect the displayed digits until the next snapshot.

Reset
REQ-022 While i_reset is high: FSM in IDLE, index 0, snapshot 0, synchronizer and history flops 0, o_frame 0, all o_com bits and all o_seg bits at their inactive level (1 when active-low).
REQ-023 Assertion of reset mid-frame shall force outputs inactive immediately, without waiting for i_clk.
REQ-024 After reset release, the block shall stay in IDLE until the first detected step; a level difference already on i_scan_clk at release shall count as one step.

Configuration
REQ-025 Macro FND_LEADING_ZERO_BLANK_EN: when defined, digits 3..1 shall show no segments (commons still scanned) when that digit and all higher digits in the snapshot are 0; digit 0 shall always be shown; a set dp bit shall still light dp on a blanked digit.
REQ-026 Without FND_LEADING_ZERO_BLANK_EN, every digit shall be decoded per REQ-018 with no blanking.

Verification
REQ-027 Reset asserted mid-DRIVE -> o_com=4'b1111 and o_seg=8'hFF asynchronously; after release, no digit is active until the first i_scan_clk toggle.
REQ-028 i_bcd=16'h1234, i_dp=0, 8 toggles of i_scan_clk each 20 cycles apart -> o_com sequence 1110,1101,1011,0111 repeats with segments for 4,3,2,1; one all-off cycle before each digit; o_frame pulses twice.
REQ-029 i_scan_clk toggled at edge k -> o_com inactive after edge k+2 and next digit active after edge k+3, checked cycle-exactly.
REQ-030 i_bcd changed from 16'h1234 to 16'h5678 while digit 1 is active -> digits 2,3 still show 2,1; next frame shows 8,7,6,5.
REQ-031 i_bcd=16'h00A0, i_dp=4'b0100 -> digit 1 shows dash only (g); digit 2 lights dp; with FND_LEADING_ZERO_BLANK_EN, digit 3 has no segments and digit 2 shows dp only.
REQ-032 COM_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0, i_bcd=16'h0008 -> digit 0 active shows o_com=4'b0001 and o_seg=8'h7F; reset gives o_com=0 and o_seg=0.
